// File: rtl/demux4_frame_pkg.sv
// Shared types and default sizing for the 2-bit symbol to lane demultiplexer.
package demux_pkg;

   localparam int LANES_DEF = 4;
   localparam int W_DEF     = 2;
   localparam int SEL_W     = $clog2(LANES_DEF);

   typedef enum logic {
      FILL = 1'b0,
      DONE = 1'b1
   } dmx_state_t;

endpackage

// File: rtl/demux4_frame_if.sv
// Symbol handshake and lane output bundle between a symbol source and demux4_frame.
interface demux4_frame_if
   import demux_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int W     = W_DEF
) ();

   logic                     in_valid;
   logic                     in_ready;
   logic [W-1:0]             d;
   logic [$clog2(LANES)-1:0] s;
   logic [LANES*W-1:0]       y;
   logic [LANES-1:0]         lane_vld;
   logic                     frame_done;

   modport master (
      output in_valid, d, s,
      input  in_ready, y, lane_vld, frame_done
   );

   modport slave (
      input  in_valid, d, s,
      output in_ready, y, lane_vld, frame_done
   );

endinterface

// File: rtl/demux4_frame_lane_reg.sv
// One W-bit lane register with write enable and a per-frame valid flag.
module dmx_lane_reg #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_we,
   input  logic [W-1:0] i_d,
   input  logic         i_clr,
   output logic [W-1:0] o_q,
   output logic         o_vld
);

   logic [W-1:0] r_q;
   logic         r_vld;

   // Data is only cleared by reset; the valid flag is cleared per frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q   <= '0;
         r_vld <= 1'b0;
      end else begin
         if (i_we) begin
            r_q   <= i_d;
            r_vld <= 1'b1;
         end else if (i_clr) begin
            r_vld <= 1'b0;
         end
      end
   end

   assign o_q   = r_q;
   assign o_vld = r_vld;

endmodule

// File: rtl/demux4_frame.sv
// Steers one W-bit symbol per handshake into LANES registered lanes and pulses frame_done when all are filled.
// Optional AUTO_SEL_EN: lanes are filled in order from an internal pointer instead of the s input.
//
// state | meaning
// FILL  | accepting symbols, collecting lanes for the current frame
// DONE  | one-cycle frame pulse, input stalled, lane valid flags cleared on exit
module demux4_frame
   import demux_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int W     = W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   demux4_frame_if.slave  bus
);

   localparam int SW = $clog2(LANES);

   dmx_state_t         r_state;
   dmx_state_t         w_state_nxt;
   logic               w_accept;
   logic               w_clr_vld;
   logic [SW-1:0]      w_sel;
   logic [LANES-1:0]   w_we;
   logic [LANES-1:0]   w_vld;
   logic [LANES*W-1:0] w_y;

   assign bus.in_ready   = (r_state == FILL);
   assign bus.frame_done = (r_state == DONE);
   assign w_clr_vld      = (r_state == DONE);
   assign w_accept       = bus.in_valid & bus.in_ready;

`ifdef AUTO_SEL_EN
   logic [SW-1:0] r_ptr;

   // Pointer wraps naturally because LANES is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (r_state == DONE) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= r_ptr + SW'(1);
      end
   end

   assign w_sel = r_ptr;
`else
   assign w_sel = bus.s;
`endif

   always_comb begin
      w_we = '0;
      if (w_accept) begin
         w_we[w_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The completing accept is seen through the write enable, before the flag registers update.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FILL: begin
            if (w_accept && (&(w_vld | w_we))) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = FILL;
         end
         default: begin
            w_state_nxt = FILL;
         end
      endcase
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      dmx_lane_reg #(
         .W (W)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .i_we  (w_we[g]),
         .i_d   (bus.d),
         .i_clr (w_clr_vld),
         .o_q   (w_y[g*W +: W]),
         .o_vld (w_vld[g])
      );
   end

   assign bus.y        = w_y;
   assign bus.lane_vld = w_vld;

endmodule

// File: tb/tb_demux4_frame.sv
// Directed self-checking bench for demux4_frame; the AUTO_SEL_EN build runs the pointer scenario instead.
module tb_demux4_frame;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   demux4_frame_if #(.LANES(4), .W(2)) u_if ();

   demux4_frame #(
      .LANES (4),
      .W     (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] d);
      u_if.in_valid = v;
      u_if.s        = s;
      u_if.d        = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 2'd0, 2'd0);
      tick();
      tick();
      rst = 1'b0;
      drive(1'b1, 2'd0, 2'b11);
      tick();
      drive(1'b0, 2'd0, 2'd0);
      n_checks++;
      if (u_if.y !== 8'h03) begin
         n_fail++;
         $display("FAIL pre_reset_write: y=%h expected 03", u_if.y);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (u_if.y !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_y: y=%h expected 00", u_if.y);
      end
      n_checks++;
      if (u_if.lane_vld !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_lane_vld: got %b expected 0000", u_if.lane_vld);
      end
      n_checks++;
      if (u_if.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 1", u_if.in_ready);
      end
      n_checks++;
      if (u_if.frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_frame_done: got %b expected 0", u_if.frame_done);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      drive(1'b1, 2'd0, 2'b01);
      tick();
      n_checks++;
      if (u_if.lane_vld !== 4'b0001 || u_if.y !== 8'h01) begin
         n_fail++;
         $display("FAIL fill_first: y=%h vld=%b expected 01/0001", u_if.y, u_if.lane_vld);
      end
      drive(1'b1, 2'd1, 2'b10);
      tick();
      drive(1'b1, 2'd2, 2'b11);
      tick();
      n_checks++;
      if (u_if.frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_early_done: got %b expected 0", u_if.frame_done);
      end
      drive(1'b1, 2'd3, 2'b00);
      tick();
      drive(1'b0, 2'd0, 2'd0);
      n_checks++;
      if (u_if.y !== 8'b00_11_10_01) begin
         n_fail++;
         $display("FAIL fill_y: y=%b expected 00111001", u_if.y);
      end
      n_checks++;
      if (u_if.frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_frame_done: got %b expected 1", u_if.frame_done);
      end
      n_checks++;
      if (u_if.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_in_ready_done: got %b expected 0", u_if.in_ready);
      end
      tick();
      n_checks++;
      if (u_if.lane_vld !== 4'b0000 || u_if.frame_done !== 1'b0 || u_if.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_after_done: vld=%b fd=%b rdy=%b expected 0000/0/1",
                  u_if.lane_vld, u_if.frame_done, u_if.in_ready);
      end
      n_checks++;
      if (u_if.y !== 8'h39) begin
         n_fail++;
         $display("FAIL fill_y_hold: y=%h expected 39", u_if.y);
      end
   endtask

   task automatic test_overwrite();
      drive(1'b1, 2'd2, 2'b11);
      tick();
      drive(1'b1, 2'd2, 2'b01);
      tick();
      drive(1'b0, 2'd3, 2'b11);
      tick();
      n_checks++;
      if (u_if.y[5:4] !== 2'b01 || u_if.y !== 8'b00_01_10_01) begin
         n_fail++;
         $display("FAIL overwrite_y: y=%b expected 00011001", u_if.y);
      end
      n_checks++;
      if (u_if.lane_vld !== 4'b0100) begin
         n_fail++;
         $display("FAIL overwrite_lane_vld: got %b expected 0100", u_if.lane_vld);
      end
      n_checks++;
      if (u_if.frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL overwrite_frame_done: got %b expected 0", u_if.frame_done);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 2'd0, 2'b00);
      tick();
      drive(1'b1, 2'd1, 2'b00);
      tick();
      drive(1'b1, 2'd3, 2'b11);
      tick();
      drive(1'b1, 2'd1, 2'b10);
      n_checks++;
      if (u_if.frame_done !== 1'b1 || u_if.y !== 8'b11_01_00_00) begin
         n_fail++;
         $display("FAIL bp_done: fd=%b y=%b expected 1/11010000", u_if.frame_done, u_if.y);
      end
      tick();
      n_checks++;
      if (u_if.y !== 8'b11_01_00_00 || u_if.lane_vld !== 4'b0000) begin
         n_fail++;
         $display("FAIL bp_not_accepted: y=%b vld=%b expected 11010000/0000", u_if.y, u_if.lane_vld);
      end
      tick();
      drive(1'b0, 2'd0, 2'd0);
      n_checks++;
      if (u_if.y[3:2] !== 2'b10 || u_if.lane_vld !== 4'b0010) begin
         n_fail++;
         $display("FAIL bp_accepted: y=%b vld=%b expected y[3:2]=10/0010", u_if.y, u_if.lane_vld);
      end
   endtask

   task automatic test_reset_mid_frame();
      drive(1'b1, 2'd0, 2'b11);
      tick();
      drive(1'b1, 2'd2, 2'b10);
      tick();
      drive(1'b0, 2'd0, 2'd0);
      n_checks++;
      if (u_if.lane_vld !== 4'b0111) begin
         n_fail++;
         $display("FAIL mid_partial: vld=%b expected 0111", u_if.lane_vld);
      end
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (u_if.y !== 8'h00 || u_if.lane_vld !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_reset: y=%h vld=%b expected 00/0000", u_if.y, u_if.lane_vld);
      end
      drive(1'b1, 2'd3, 2'b01);
      tick();
      drive(1'b0, 2'd0, 2'd0);
      n_checks++;
      if (u_if.frame_done !== 1'b0 || u_if.lane_vld !== 4'b1000) begin
         n_fail++;
         $display("FAIL mid_no_done: fd=%b vld=%b expected 0/1000", u_if.frame_done, u_if.lane_vld);
      end
   endtask

   task automatic test_auto_sel();
      logic [1:0] syms [4];
      syms = '{2'b01, 2'b10, 2'b11, 2'b00};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'd3, syms[i]);
         tick();
      end
      drive(1'b1, 2'd3, 2'b11);
      n_checks++;
      if (u_if.y !== 8'b00_11_10_01) begin
         n_fail++;
         $display("FAIL auto_y: y=%b expected 00111001", u_if.y);
      end
      n_checks++;
      if (u_if.frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL auto_done: got %b expected 1", u_if.frame_done);
      end
      tick();
      tick();
      drive(1'b0, 2'd3, 2'd0);
      n_checks++;
      if (u_if.y[1:0] !== 2'b11 || u_if.y !== 8'b00_11_10_11) begin
         n_fail++;
         $display("FAIL auto_wrap: y=%b expected 00111011", u_if.y);
      end
      n_checks++;
      if (u_if.lane_vld !== 4'b0001) begin
         n_fail++;
         $display("FAIL auto_lane_vld: got %b expected 0001", u_if.lane_vld);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
`ifdef AUTO_SEL_EN
      test_auto_sel();
`else
      test_fill();
      test_overwrite();
      test_back_to_back();
      test_reset_mid_frame();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
